// File: rtl/prism_out_capture.sv
// Timestamped change-capture FIFO for the PRISM out_data bus.
// Each change of the monitored word is queued with a free-running timestamp.
module prism_out_capture #(
  parameter  int DEPTH = 8,
  parameter  int DW    = 13,
  parameter  int TSW   = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clear,
  input  logic [DW-1:0] out_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  input  logic [CW-1:0] thresh,
  output logic          irq
);

  localparam int AW  = CW - 1;
  localparam int PAD = 32 - TSW - DW;

  logic [DW-1:0]  prev;
  logic [TSW-1:0] ts;
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [CW-1:0]  cnt;
  logic           ovf;

  logic [DW-1:0]  mem_d [DEPTH];
  logic [TSW-1:0] mem_t [DEPTH];

  logic chg;
  logic push;
  logic pop;

  assign chg  = enable && (out_data != prev);
  assign pop  = rd_en && !empty;
  // A pop on a full FIFO frees the slot the push needs.
  assign push = chg && (!full || pop);

  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign overflow = ovf;
  assign irq      = (thresh != '0) && (cnt >= thresh);

  assign rd_data = empty ? 32'd0
                 : {mem_t[rptr], {PAD{1'b0}}, mem_d[rptr]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= out_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (clear) begin
      ts <= '0;
    end else if (enable) begin
      ts <= ts + TSW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (chg && !push) begin
        ovf <= 1'b1;
      end
    end
  end

  // Storage is deliberately left unreset; only pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_d[wptr] <= out_data;
      mem_t[wptr] <= ts;
    end
  end

endmodule

// File: tb/tb_prism_out_capture.sv
// Directed bench for prism_out_capture.
// Each task drives one scenario and checks outputs inline.
module tb_prism_out_capture;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [12:0]   out_data = '0;
  logic          rd_en = 1'b0;
  logic [31:0]   rd_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic [CW-1:0] thresh = '0;
  logic          irq;

  int checks = 0;
  int failures = 0;

  prism_out_capture #(.DEPTH(DEPTH), .DW(13), .TSW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clear    (clear),
    .out_data (out_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .thresh   (thresh),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    enable = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full);
    end
    checks++;
    if (overflow !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf_irq ovf=%b irq=%b exp 0/0", overflow, irq);
    end
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_rd_data got=%h exp=0", rd_data);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_first_capture();
    enable = 1'b1;
    repeat (5) step();
    out_data = 13'h055;
    step();
    checks++;
    if (count !== 4'd1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL first_count count=%0d empty=%b exp 1/0", count, empty);
    end
    checks++;
    if (rd_data !== 32'h0005_0055) begin
      failures++;
      $display("FAIL first_rd_data got=%h exp=00050055", rd_data);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 32'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL first_pop rd_data=%h empty=%b exp 0/1", rd_data, empty);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    out_data = '0;
    do_clear();
    for (int i = 0; i < 9; i++) begin
      enable = 1'b1;
      out_data = 13'(i + 1);
      step();
    end
    enable = 1'b0;
    checks++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_state full=%b count=%0d ovf=%b exp 1/8/1",
               full, count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      exp = {16'(i), 3'b000, 13'(i + 1)};
      checks++;
      if (rd_data !== exp) begin
        failures++;
        $display("FAIL ovf_pop%0d got=%h exp=%h", i, rd_data, exp);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    checks++;
    if (empty !== 1'b1 || rd_data !== 32'd0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drained empty=%b rd=%h ovf=%b exp 1/0/1",
               empty, rd_data, overflow);
    end
  endtask

  task automatic test_clear();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      out_data = 13'h040 + 13'(i);
      step();
    end
    checks++;
    if (count !== 4'd4) begin
      failures++;
      $display("FAIL clr_pre count=%0d exp=4", count);
    end
    out_data = 13'h044;
    rd_en = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    rd_en = 1'b0;
    enable = 1'b0;
    checks++;
    if (count !== 4'd0 || overflow !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL clr_state count=%0d ovf=%b empty=%b exp 0/0/1",
               count, overflow, empty);
    end
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL clr_rd_data got=%h exp=0", rd_data);
    end
    enable = 1'b1;
    out_data = 13'h045;
    step();
    enable = 1'b0;
    checks++;
    if (count !== 4'd1 || rd_data !== 32'h0000_0045) begin
      failures++;
      $display("FAIL clr_ts count=%0d rd=%h exp 1/00000045", count, rd_data);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp;
    do_clear();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      out_data = 13'h010 + 13'(i);
      step();
    end
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fpp_fill full=%b ovf=%b exp 1/0", full, overflow);
    end
    out_data = 13'h020;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    enable = 1'b0;
    checks++;
    if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fpp_state count=%0d full=%b ovf=%b exp 8/1/0",
               count, full, overflow);
    end
    for (int j = 1; j <= 8; j++) begin
      exp = {16'(j), 3'b000, (j < 8) ? 13'(16 + j) : 13'h020};
      checks++;
      if (rd_data !== exp) begin
        failures++;
        $display("FAIL fpp_pop%0d got=%h exp=%h", j, rd_data, exp);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL fpp_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_irq();
    do_clear();
    thresh = 4'd3;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_data = 13'h030 + 13'(i);
      step();
      checks++;
      if (irq !== (i == 2)) begin
        failures++;
        $display("FAIL irq_fill%0d got=%b exp=%b", i, irq, (i == 2));
      end
    end
    enable = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (irq !== 1'b0 || count !== 4'd2) begin
      failures++;
      $display("FAIL irq_pop irq=%b count=%0d exp 0/2", irq, count);
    end
    thresh = 4'd2;
    #1;
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_thr2 got=%b exp=1", irq);
    end
    thresh = 4'd0;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_thr0 got=%b exp=0", irq);
    end
    rd_en = 1'b1;
    repeat (2) step();
    rd_en = 1'b0;
  endtask

  task automatic test_wrap_and_hold();
    do_clear();
    enable = 1'b1;
    repeat (65537) step();
    out_data = 13'h07A;
    step();
    enable = 1'b0;
    checks++;
    if (rd_data !== 32'h0001_007A) begin
      failures++;
      $display("FAIL wrap_ts got=%h exp=0001007a", rd_data);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      out_data = 13'h100 + 13'(i);
      step();
    end
    checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL dis_nocap count=%0d empty=%b exp 0/1", count, empty);
    end
    enable = 1'b1;
    out_data = 13'h1FF;
    step();
    enable = 1'b0;
    checks++;
    if (rd_data !== 32'h0002_01FF) begin
      failures++;
      $display("FAIL dis_hold got=%h exp=000201ff", rd_data);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_clear();
    enable = 1'b1;
    out_data = 13'h050;
    step();
    out_data = 13'h051;
    step();
    out_data = 13'h052;
    rd_en = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid count=%0d empty=%b rd=%h exp 0/1/0",
               count, empty, rd_data);
    end
    rd_en = 1'b0;
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (count !== 4'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_after count=%0d ovf=%b exp 0/0", count, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_first_capture();
    test_overflow();
    test_clear();
    test_full_push_pop();
    test_irq();
    test_wrap_and_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prism_out_capture.md
# prism_out_capture

Timestamped change-capture FIFO sitting directly downstream of the PRISM controller's 13-bit `out_data` bus inside the TinyQV peripheral. Whenever the FSM output word changes while capture is enabled, the block stores the new value with a 16-bit timestamp into a small FIFO. The RISC-V core drains the FIFO through the peripheral register interface. A level interrupt flags when a programmable fill threshold is reached.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, 2..16.
- `DW`, default 13: captured data width; matches PRISM `out_data`.
- `TSW`, default 16: timestamp width.

Ports (`CW` = $clog2(DEPTH)+1):
- `clk`  in  1  system clock (64 MHz nominal); the block uses only this clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  capture enable; the timestamp counter runs only while high.
- `clear`  in  1  synchronous flush: empties the FIFO, clears `overflow`, zeroes the timestamp.
- `out_data`  in  DW  PRISM output word being monitored.
- `rd_en`  in  1  pop request, one entry per cycle.
- `rd_data`  out  32  head entry `{ts[15:0], 3'b0, data[12:0]}`; reads 0 when the FIFO is empty.
- `count`  out  CW  number of valid entries.
- `empty`  out  1  asserted when `count`==0.
- `full`  out  1  asserted when `count`==DEPTH.
- `overflow`  out  1  sticky flag: at least one capture was dropped.
- `thresh`  in  CW  interrupt fill threshold; 0 disables the interrupt.
- `irq`  out  1  equals (`thresh`!=0 && `count`>=`thresh`).

## Operation
- `prev` register: loads `out_data` every cycle, whether or not `enable` is high.
  - `chg` = `enable` && (`out_data` != `prev`).
  - The first change after `enable` rises is captured. Asserting `enable` does not itself create an entry.
- Timestamp counter `ts`:
  - Increments by 1 per cycle while `enable` is high; holds while `enable` is low.
  - Wraps 0xFFFF->0x0000 with no flag.
- On `chg`, the pushed entry is {`ts` value in that cycle, `out_data` in that cycle}.
- Push when `chg` && !`full`. If `chg` && `full`, the entry is dropped and `overflow` is set.
- Pop when `rd_en` && !`empty`. `rd_en` while empty is ignored with no side effect.
- FIFO is first-word-fall-through: `rd_data` always presents the head entry.
- Storage is an array of DEPTH entries with read/write pointers of width CW-1, both wrapping modulo DEPTH. `count` is a registered counter.
- Simultaneous push and pop:
  - Not full and not empty: both happen; `count` is unchanged.
  - Full: the pop frees a slot, so the push is accepted and `overflow` is not set. `count` stays DEPTH.
  - Empty: the pop is ignored and the push is accepted.
- `clear` has highest priority. In its cycle:
  - Pointers, `count`, `ts` and `overflow` go to 0.
  - Any push or pop in that cycle is discarded.
  - `prev` still updates.
- `irq` is combinational from `count` and `thresh`, with no glitching beyond register outputs.
- Memory contents are not reset. Only pointers and flags are reset.

## Timing
- Reset values (async, while `rst_n` is low):
  - `count`, `ts`, pointers, `overflow`, `full`, `irq` = 0.
  - `empty` = 1.
  - `rd_data` = 0.
  - `prev` = 0.
- Capture latency: a change present on `out_data` at rising edge N is written at edge N. `empty`, `count`, `rd_data` and `irq` reflect it in cycle N+1.
- Pop: `rd_en` high at edge N removes the head. The next entry, or 0 if the FIFO is now empty, appears in cycle N+1.
- Back-to-back changes on consecutive cycles each create one entry. Timestamps of consecutive entries differ by exactly 1.
- `ts` captured for the first cycle after `enable` rises is the held counter value (0 after reset or `clear`).
- `rst_n` asserted mid-operation: immediate return to the reset values, with no partial pop or push.

## Test plan
- Reset, then `enable`=1 and `out_data` 0x000->0x055 at cycle 5 (`ts`=5) -> cycle 6: `count`=1, `empty`=0, `rd_data`=0x0005_0055; pulse `rd_en` -> `rd_data`=0, `empty`=1.
- Toggle `out_data` on 9 consecutive cycles with DEPTH=8 -> `full`=1, `count`=8, `overflow`=1. Popping returns 8 entries with consecutive `ts` and the ninth change missing.
- `full` with push and pop in the same cycle -> `count` stays 8, `overflow` stays 0, the head advances, and the new entry is last.
- `thresh`=3, three captures -> `irq` rises in the cycle after the third push. One pop -> `irq`=0. `thresh`=0 -> `irq` stays 0.
- 4 entries queued, then `clear` pulsed together with a change and `rd_en` -> next cycle `count`=0, `overflow`=0, `ts`=0, nothing captured.
- `enable`=1 for 65537 cycles with a change at the end -> stored `ts`=0x0001, confirming wrap. `enable`=0 with changes -> no entries, `ts` holds.
